// File: rtl/binary_2_bcd_seq_pkg.sv
// Shared types, constants and sizing helper for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // ceil(w*log10(2)); w*log10(2) is never an exact integer for w >= 1.
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/binary_2_bcd_seq_if.sv
// Upstream word handshake and downstream result handshake of the converter.
interface binary_2_bcd_seq_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    // Both sides are valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; valid and its payload hold until that edge.
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_W-1:0]     i_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [4*DIGITS-1:0]   o_bcd;
    logic [DIGITS-1:0]     o_blank;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_bcd, o_blank
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_bcd, o_blank
    );

endinterface

// File: rtl/binary_2_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= BCD_ADJ_THRESH) ? (d_i + BCD_ADJ_ADD) : d_i;

endmodule

// File: rtl/binary_2_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with leading-zero blanking mask.
module binary_2_bcd_seq
    import bcd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    binary_2_bcd_seq_if.slave  bus,
    output b2b_state_e         o_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    if (DATA_W < 4 || DATA_W > 32) begin : g_bad_width
        $error("binary_2_bcd_seq: DATA_W must be within 4..32");
    end
    if (DIGITS < min_digits(DATA_W)) begin : g_bad_digits
        $error("binary_2_bcd_seq: DIGITS too small for DATA_W");
    end

    b2b_state_e         state_q;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_adj, bcd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q, valid_q;
    logic [BCD_W-1:0]   out_bcd_q;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               nz;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (bcd_q[4*k +: 4]),
            .d_o (bcd_adj[4*k +: 4])
        );
    end

    assign {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;

    // Blank bit k is set when digit k and every digit above it are zero; units never blank.
    always_comb begin
        nz      = 1'b0;
        blank_d = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nz         = nz | (bcd_d[4*k +: 4] != 4'd0);
            blank_d[k] = ~nz;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            out_bcd_q <= '0;
            blank_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && ready_q) begin
                        bin_q   <= bus.i_data;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The last shift result goes straight to the output registers.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        out_bcd_q <= bcd_d;
                        blank_q   <= blank_d;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_bcd   = out_bcd_q;
    assign bus.o_blank = blank_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_binary_2_bcd_seq.sv
// Bench for binary_2_bcd_seq: an 8-bit/3-digit and a 16-bit/5-digit instance against a decimal model.
module tb_binary_2_bcd_seq;
    import bcd_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    binary_2_bcd_seq_if #(.DATA_W(8),  .DIGITS(3)) if8  ();
    binary_2_bcd_seq_if #(.DATA_W(16), .DIGITS(5)) if16 ();
    b2b_state_e st8, st16;

    binary_2_bcd_seq #(.DATA_W(8), .DIGITS(3)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if8),
        .o_state (st8)
    );

    binary_2_bcd_seq #(.DATA_W(16), .DIGITS(5)) dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if16),
        .o_state (st16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by repeated division, units first.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Digits at or above the count of significant decimal digits are blanked.
    function automatic logic [63:0] ref_blank(input longint unsigned v, input int digits);
        logic [63:0]     r;
        int              n;
        longint unsigned t;
        n = 1;
        t = v / 10;
        while (t != 0) begin
            n++;
            t = t / 10;
        end
        r = '0;
        for (int k = 0; k < digits; k++) r[k] = (k >= n);
        return r;
    endfunction

    function automatic logic get_ovalid(input bit sel);
        return sel ? if16.o_valid : if8.o_valid;
    endfunction

    function automatic logic get_oready(input bit sel);
        return sel ? if16.o_ready : if8.o_ready;
    endfunction

    function automatic logic [63:0] get_bcd(input bit sel);
        return sel ? 64'(if16.o_bcd) : 64'(if8.o_bcd);
    endfunction

    function automatic logic [63:0] get_blank(input bit sel);
        return sel ? 64'(if16.o_blank) : 64'(if8.o_blank);
    endfunction

    function automatic b2b_state_e get_state(input bit sel);
        return sel ? st16 : st8;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [31:0] d, input logic r);
        if (sel) begin
            if16.i_valid = v;
            if16.i_data  = d[15:0];
            if16.i_ready = r;
        end else begin
            if8.i_valid = v;
            if8.i_data  = d[7:0];
            if8.i_ready = r;
        end
    endtask

    // One full transaction: accept, latency, result, optional backpressure, release.
    task automatic convert(input bit sel, input longint unsigned v, input int hold, input string tag);
        int          w;
        int          dg;
        int          c;
        bit          ready_low;
        bit          stable;
        logic [63:0] exp_bcd;
        logic [63:0] exp_blank;
        w         = sel ? 16 : 8;
        dg        = sel ? 5 : 3;
        exp_bcd   = ref_bcd(v, dg);
        exp_blank = ref_blank(v, dg);
        @(negedge clk);
        drive(sel, 1'b1, 32'(v), 1'b0);
        c = 0;
        while (!get_oready(sel) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check({tag, " accept"}, 64'(get_oready(sel)), 64'd1);
        c         = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) drive(sel, 1'b0, 32'd0, 1'b0);
            if (get_oready(sel)) ready_low = 1'b0;
        end while (!get_ovalid(sel) && c < 100);
        check({tag, " latency"}, 64'(c), 64'(w + 1));
        check({tag, " busy_ready"}, 64'(ready_low), 64'd1);
        check({tag, " bcd"}, get_bcd(sel), exp_bcd);
        check({tag, " blank"}, get_blank(sel), exp_blank);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (get_bcd(sel) !== exp_bcd || get_blank(sel) !== exp_blank ||
                get_ovalid(sel) !== 1'b1 || get_oready(sel) !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check({tag, " hold"}, 64'(stable), 64'd1);
        drive(sel, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check({tag, " release"},
              {61'd0, get_ovalid(sel), get_oready(sel), get_state(sel) == IDLE}, 64'b011);
        drive(sel, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst8 ready_valid", {62'd0, if8.o_valid, if8.o_ready}, 64'b01);
        check("rst8 bcd_blank", {49'd0, if8.o_bcd, if8.o_blank}, 64'd0);
        check("rst16 ready_valid", {62'd0, if16.o_valid, if16.o_ready}, 64'b01);
        check("rst16 bcd_blank", {39'd0, if16.o_bcd, if16.o_blank}, 64'd0);
        check("rst state", {60'd0, st8, st16}, {60'd0, IDLE, IDLE});
        rst_n = 1'b1;

        convert(1'b0, 255, 0, "d8_255");
        convert(1'b0, 0, 2, "d8_zero");
        convert(1'b0, 42, 1, "d8_42");
        convert(1'b0, 255, 20, "d8_backpressure");
        convert(1'b1, 65535, 0, "d16_ffff");
        convert(1'b1, 100, 3, "d16_100");
        convert(1'b1, 0, 1, "d16_zero");

        // Result release and a pending word in the same cycle: one idle bubble.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd200, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        c = 1;
        while (!if8.o_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("bubble first_lat", 64'(c), 64'd9);
        check("bubble first_bcd", 64'(if8.o_bcd), 64'h200);
        drive(1'b0, 1'b1, 32'd13, 1'b1);
        @(negedge clk);
        check("bubble idle", {61'd0, if8.o_valid, if8.o_ready, st8 == IDLE}, 64'b011);
        drive(1'b0, 1'b1, 32'd13, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check("bubble accepted", {62'd0, if8.o_ready, st8 == SHIFT}, 64'b01);
        c = 1;
        while (!if8.o_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("bubble second_lat", 64'(c), 64'd9);
        check("bubble second_bcd", 64'(if8.o_bcd), 64'h013);
        check("bubble second_blank", 64'(if8.o_blank), 64'b100);
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd99, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst ready_valid", {62'd0, if8.o_valid, if8.o_ready}, 64'b01);
        check("midrst bcd_state", {50'd0, if8.o_bcd, st8}, {62'd0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        convert(1'b0, 7, 1, "post_rst_7");

        for (int i = 0; i < 12; i++) begin
            convert(1'b0, longint'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "rnd8");
            convert(1'b1, longint'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), "rnd16");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
